// File: rtl/rv_regwb_pkg.sv
// rv_regwb_pkg: shared widths, parameter defaults and arbiter state encoding for the writeback arbiter
package rv_regwb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int ENTRY_W = REG_AW + XLEN;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int STARVE_MAX_DEF = 4;
  typedef enum logic {NORMAL = 1'b0, STARVE = 1'b1} arb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: power-of-2 FIFO for MDU results; ports clk/rst, push+din, pop, full/empty, dout=head
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: scoreboard + arbiter sharing one regfile write port between pipeline writeback (wb_*) and buffered MDU results (mdu_*); issue_*/q_*/hazard/pending track outstanding MDU writes
module regfile_wb_arbiter
  import rv_regwb_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  output logic              wb_stall,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_wd,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  input  logic [REG_AW-1:0] q_rd,
  output logic              hazard,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_wd3,
  output logic [31:0]       pending
);
  localparam int CW = $clog2(STARVE_MAX + 2);
  arb_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic full, empty, push, pop, wb_ok, pipe_gnt, buf_gnt, starve;
  logic [ENTRY_W-1:0] head;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0] head_wd;
  logic [31:0] set, clr;
  assign {head_rd, head_wd} = head;
  wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din({mdu_rd, mdu_wd}),
    .pop(pop), .full(full), .empty(empty), .dout(head)
  );
  always_comb begin
    starve = state == STARVE;
    wb_ok = wb_we && wb_rd != '0;
    buf_gnt = !empty && (starve || !wb_ok);
    pipe_gnt = !starve && wb_ok;
    pop = buf_gnt && !rst;
    mdu_ready = !full;
    push = mdu_valid && !full && mdu_rd != '0;
    rf_we = (buf_gnt || pipe_gnt) && !rst;
    rf_a3 = !rf_we ? '0 : buf_gnt ? head_rd : wb_rd;
    rf_wd3 = !rf_we ? '0 : buf_gnt ? head_wd : wb_wd;
    wb_stall = buf_gnt && starve && wb_ok;
    issue_ready = !pending[issue_rd];
    hazard = pending[q_rs1] | pending[q_rs2] | pending[q_rd];
    set = (issue_valid && issue_ready && issue_rd != '0) ? 32'd1 << issue_rd : '0;
    clr = pop ? 32'd1 << head_rd : '0;
    // streak of pipeline wins only counts while results are waiting
    cnt_n = (pop || empty) ? '0 : pipe_gnt ? cnt + 1'b1 : cnt;
    state_n = pop ? NORMAL : (cnt_n == CW'(STARVE_MAX)) ? STARVE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      cnt <= '0;
      state <= NORMAL;
    end else begin
      pending <= ((pending & ~clr) | set) & ~32'd1;
      cnt <= cnt_n;
      state <= state_n;
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, MDU result buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive pipeline-priority cycles tolerated while the buffer is non-empty.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports wb_we/wb_rd/wb_wd  in  1/5/32  pipeline writeback request.
REQ-006 SHALL have port wb_stall  out  1  pipeline SHALL hold its wb_* request this cycle.
REQ-007 SHALL have ports issue_valid/issue_rd  in  1/5  MDU op dispatch, with issue_ready  out  1.
REQ-008 SHALL have ports mdu_valid/mdu_rd/mdu_wd  in  1/5/32  MDU result, with mdu_ready  out  1.
REQ-009 SHALL have ports q_rs1/q_rs2/q_rd  in  5 each, and hazard  out  1  pending-write query.
REQ-010 SHALL have ports rf_we/rf_a3/rf_wd3  out  1/5/32  register file write port; pending  out  32  scoreboard bitmap.

Function
REQ-011 Scoreboard: issue accepted when issue_valid && issue_ready; issue_ready = !pending[issue_rd] || issue_rd==0.
REQ-012 Accepted issue with issue_rd!=0 SHALL set pending[issue_rd] at that edge; x0 never sets a bit; pending[0] always 0.
REQ-013 pending[r] SHALL clear at the edge where the buffer head with rd=r is written to the port.
REQ-014 hazard SHALL be combinational: pending[q_rs1] | pending[q_rs2] | pending[q_rd].
REQ-015 mdu_ready = buffer not full; result pushed on mdu_valid && mdu_ready; pushes with mdu_rd==0 SHALL be discarded (no entry).
REQ-016 Port select, combinational, per cycle: starve mode -> buffer head; else wb_we && wb_rd!=0 -> pipeline; else buffer non-empty -> buffer head; else idle.
REQ-017 Pipeline granted: rf_we=1, rf_a3=wb_rd, rf_wd3=wb_wd, wb_stall=0.
REQ-018 Buffer granted: rf_we=1, rf_a3/rf_wd3 = head, pop at edge; wb_stall = starve mode && wb_we.
REQ-019 wb_we with wb_rd==0 SHALL produce rf_we=0 and wb_stall=0 (write dropped).
REQ-020 Idle: rf_we=0, rf_a3=0, rf_wd3=0.
REQ-021 Latency: result pushed at edge N SHALL be eligible for the port in cycle N+1; no same-cycle bypass from mdu_* to rf_*.
REQ-022 Starve counter: increments each cycle pipeline is granted while buffer non-empty; resets to 0 on any buffer pop or when buffer empty.
REQ-023 States NORMAL/STARVE: NORMAL->STARVE when counter==STARVE_MAX; STARVE lasts exactly one cycle (one pop) then NORMAL.
REQ-024 Full buffer with simultaneous pop and mdu_valid: mdu_ready stays 0 that cycle (no push-on-pop-when-full).
REQ-025 Simultaneous issue setting pending[a] and pop clearing pending[b], a!=b: both SHALL take effect.
REQ-026 Buffer pointers SHALL wrap modulo FIFO_DEPTH; order strictly FIFO.

Reset
REQ-027 While rst=1 at an edge: pending=0, buffer empty, pointers=0, counter=0, state NORMAL.
REQ-028 Out of reset: rf_we=0, wb_stall=0, hazard=0, mdu_ready=1, issue_ready=1 (before inputs toggle).
REQ-029 Reset mid-operation SHALL discard all buffered results and pending bits without any port write in the reset cycle.

Structure
REQ-030 Shared package rv_regwb_pkg SHALL hold XLEN=32, REG_AW=5, defaults for FIFO_DEPTH and STARVE_MAX, and the NORMAL/STARVE state encoding.
REQ-031 Buffer SHALL be a separate sub-module wb_fifo (parameterised width 37, depth FIFO_DEPTH, push/pop/full/empty).
REQ-032 No register array storage beyond the buffer and 32-bit bitmap; target 150-300 RTL lines.

Verification
REQ-033 Issue rd=5, MDU returns rd=5 wd=0xDEADBEEF with wb_we=0 -> next cycle rf_we=1, rf_a3=5, rf_wd3=0xDEADBEEF; pending[5] 1 -> 0 after that edge.
REQ-034 Issue rd=7 then q_rs1=7 -> hazard=1; second issue rd=7 -> issue_ready=0 until writeback.
REQ-035 Buffer holds rd=3, wb_we=1 continuously with rd=9 -> 4 pipeline grants, 5th cycle wb_stall=1, rf_a3=3; 6th cycle pipeline rd=9 granted.
REQ-036 Push 2 results (FIFO_DEPTH=2) under continuous wb_we -> mdu_ready=0 while full; third result held by MDU, no loss, order preserved.
REQ-037 wb_we=1 wb_rd=0 with empty buffer -> rf_we=0; MDU result rd=0 -> never written, mdu_ready unaffected.
REQ-038 Assert rst with 2 buffered entries and pending=0x88 -> next cycle pending=0, rf_we=0, mdu_ready=1.
